// File: rtl/pipeline_pkg.sv
// Shared constants for the fetch/decode pipeline register and its decoder.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR = 32'hE320F000;

    localparam logic [2:0] CLS_DP_IMMSH = 3'b000;
    localparam logic [2:0] CLS_DP_IMM   = 3'b001;
    localparam logic [2:0] CLS_NOP      = 3'b010;
    localparam logic [2:0] CLS_DP_REGSH = 3'b011;
    localparam logic [2:0] CLS_LS_IMM   = 3'b100;
    localparam logic [2:0] CLS_LS_REG   = 3'b101;
    localparam logic [2:0] CLS_BRANCH   = 3'b110;

    localparam logic [6:0] OPC_NOP = {CLS_NOP, 4'b0000};

    function automatic logic [6:0] mk_opc(input logic [2:0] cls, input logic [3:0] op);
        return {cls, op};
    endfunction

endpackage

// File: rtl/pipeline_unit_if.sv
// Fetch-side inputs and execute-side decoded fields of the fetch/decode register.
interface pipeline_unit_if;
    logic [31:0] instr_in;
    logic        branch_ref;
    logic        branch_in;
    logic        sel_stall;
    logic [3:0]  cond;
    logic [6:0]  opcode;
    logic        en_status;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rm;
    logic [1:0]  shift_op;
    logic [4:0]  imm5;
    logic [11:0] imm12;
    logic [23:0] imm24;
    logic        P;
    logic        U;
    logic        W;
    logic        branch_value;

    // There is no handshake: the fetch side drives a new instruction every cycle,
    // sel_stall=1 freezes the register, and the execute side samples fields each cycle.
    modport master (
        output instr_in, branch_ref, branch_in, sel_stall,
        input  cond, opcode, en_status, rn, rd, rs, rm, shift_op,
        input  imm5, imm12, imm24, P, U, W, branch_value
    );

    modport slave (
        input  instr_in, branch_ref, branch_in, sel_stall,
        output cond, opcode, en_status, rn, rd, rs, rm, shift_op,
        output imm5, imm12, imm24, P, U, W, branch_value
    );
endinterface

// File: rtl/pipeline_unit_instr_decoder.sv
// Combinational ARM32 decoder: field slices plus internal opcode classification.
module instr_decoder
    import pipeline_pkg::*;
(
    input  logic [31:0] d_i,
    output logic [3:0]  cond_o,
    output logic [6:0]  opcode_o,
    output logic        en_status_o,
    output logic [3:0]  rn_o,
    output logic [3:0]  rd_o,
    output logic [3:0]  rs_o,
    output logic [3:0]  rm_o,
    output logic [1:0]  shift_op_o,
    output logic [4:0]  imm5_o,
    output logic [11:0] imm12_o,
    output logic [23:0] imm24_o,
    output logic        p_o,
    output logic        u_o,
    output logic        w_o
);
    logic misc_form;

    assign cond_o     = d_i[31:28];
    assign rn_o       = d_i[19:16];
    assign rd_o       = d_i[15:12];
    assign rs_o       = d_i[11:8];
    assign rm_o       = d_i[3:0];
    assign shift_op_o = d_i[6:5];
    assign imm5_o     = d_i[11:7];
    assign imm12_o    = d_i[11:0];
    assign imm24_o    = d_i[23:0];
    assign p_o        = d_i[24];
    assign u_o        = d_i[23];
    assign w_o        = d_i[21];

    // Compare-style encodings with S=0 (misc, MSR, hints) are not executed here.
    assign misc_form = (d_i[24:23] == 2'b10) && !d_i[20];

    always_comb begin
        opcode_o    = OPC_NOP;
        en_status_o = 1'b0;
        if (d_i[31:28] != 4'b1111) begin
            case (d_i[27:25])
                3'b000: begin
                    if (misc_form) begin
                        opcode_o = OPC_NOP;
                    end else if (!d_i[4]) begin
                        opcode_o    = mk_opc(CLS_DP_IMMSH, d_i[24:21]);
                        en_status_o = d_i[20];
                    end else if (!d_i[7]) begin
                        opcode_o    = mk_opc(CLS_DP_REGSH, d_i[24:21]);
                        en_status_o = d_i[20];
                    end
                end
                3'b001: begin
                    if (!misc_form) begin
                        opcode_o    = mk_opc(CLS_DP_IMM, d_i[24:21]);
                        en_status_o = d_i[20];
                    end
                end
                3'b010: opcode_o = mk_opc(CLS_LS_IMM, {2'b00, d_i[22], d_i[20]});
                3'b011: begin
                    if (!d_i[4]) begin
                        opcode_o = mk_opc(CLS_LS_REG, {2'b00, d_i[22], d_i[20]});
                    end
                end
                3'b101: opcode_o = mk_opc(CLS_BRANCH, {3'b000, d_i[24]});
                default: opcode_o = OPC_NOP;
            endcase
        end
    end
endmodule

// File: rtl/pipeline_unit.sv
// Fetch/decode pipeline register: captures instruction and branch-epoch tag,
// substitutes a NOP for wrong-epoch instructions, and decodes the result.
module pipeline_unit
    import pipeline_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    pipeline_unit_if.slave  bus
);
    logic [31:0] instr_q, instr_d;
    logic        branch_q, branch_d;
    logic [31:0] dec_in;

    always_comb begin
        instr_d  = instr_q;
        branch_d = branch_q;
        if (!bus.sel_stall) begin
            instr_d  = bus.instr_in;
            branch_d = bus.branch_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q  <= NOP_INSTR;
            branch_q <= 1'b0;
        end else begin
            instr_q  <= instr_d;
            branch_q <= branch_d;
        end
    end

    // The squash is combinational on branch_ref so a redirect kills the
    // held instruction immediately; instr_q itself is never overwritten.
    assign dec_in = (branch_q == bus.branch_ref) ? instr_q : NOP_INSTR;

    assign bus.branch_value = branch_q;

    instr_decoder u_dec (
        .d_i         (dec_in),
        .cond_o      (bus.cond),
        .opcode_o    (bus.opcode),
        .en_status_o (bus.en_status),
        .rn_o        (bus.rn),
        .rd_o        (bus.rd),
        .rs_o        (bus.rs),
        .rm_o        (bus.rm),
        .shift_op_o  (bus.shift_op),
        .imm5_o      (bus.imm5),
        .imm12_o     (bus.imm12),
        .imm24_o     (bus.imm24),
        .p_o         (bus.P),
        .u_o         (bus.U),
        .w_o         (bus.W)
    );
endmodule

// File: tb/tb_pipeline_unit.sv
// Bench for pipeline_unit: directed vector table, hand sequences, random vs. reference model.
module tb_pipeline_unit;
  localparam int OW = 75;
  localparam logic [31:0] NOP_W = 32'hE320F000;

  logic clk;
  logic rst;
  pipeline_unit_if bus ();

  pipeline_unit dut (.clk(clk), .rst(rst), .bus(bus));

  // ---------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // reference state: what the pipeline register should hold
  logic [31:0] m_instr;
  logic        m_tag;

  logic [OW-1:0] act;
  assign act = {bus.cond, bus.opcode, bus.en_status, bus.rn, bus.rd, bus.rs, bus.rm,
                bus.shift_op, bus.imm5, bus.imm12, bus.imm24, bus.P, bus.U, bus.W,
                bus.branch_value};

  // ---------------- reference model: first-match rule table on bit masks
  typedef enum int {K_NOP, K_DP, K_LS, K_BR} kind_t;
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    kind_t       kind;
    logic [2:0]  cls;
  } rule_t;
  rule_t rules[11];

  initial begin
    rules[0]  = '{32'hF000_0000, 32'hF000_0000, K_NOP, 3'd2};
    rules[1]  = '{32'h0F90_0000, 32'h0100_0000, K_NOP, 3'd2};
    rules[2]  = '{32'h0E00_0010, 32'h0000_0000, K_DP,  3'd0};
    rules[3]  = '{32'h0E00_0090, 32'h0000_0010, K_DP,  3'd3};
    rules[4]  = '{32'h0E00_0090, 32'h0000_0090, K_NOP, 3'd2};
    rules[5]  = '{32'h0F90_0000, 32'h0300_0000, K_NOP, 3'd2};
    rules[6]  = '{32'h0E00_0000, 32'h0200_0000, K_DP,  3'd1};
    rules[7]  = '{32'h0E00_0000, 32'h0400_0000, K_LS,  3'd4};
    rules[8]  = '{32'h0E00_0010, 32'h0600_0000, K_LS,  3'd5};
    rules[9]  = '{32'h0E00_0010, 32'h0600_0010, K_NOP, 3'd2};
    rules[10] = '{32'h0E00_0000, 32'h0A00_0000, K_BR,  3'd6};
  end

  function automatic logic [OW-1:0] model_out(logic [31:0] ins, logic tag, logic bref);
    logic [31:0] d;
    logic [6:0]  opc;
    logic        en;
    bit          hit;
    d   = (tag == bref) ? ins : NOP_W;
    opc = 7'b0100000;
    en  = 1'b0;
    hit = 0;
    for (int i = 0; i < 11; i++) begin
      if (!hit && ((d & rules[i].mask) == rules[i].match)) begin
        hit = 1;
        case (rules[i].kind)
          K_DP: begin opc = {rules[i].cls, d[24:21]}; en = d[20]; end
          K_LS: opc = {rules[i].cls, 2'b00, d[22], d[20]};
          K_BR: opc = {rules[i].cls, 3'b000, d[24]};
          default: opc = 7'b0100000;
        endcase
      end
    end
    return {d[31:28], opc, en, d[19:16], d[15:12], d[11:8], d[3:0], d[6:5], d[11:7],
            d[11:0], d[23:0], d[24], d[23], d[21], tag};
  endfunction

  // ---------------- scoreboard
  logic [OW-1:0] exp_q[$];

  task automatic check(input string name, input logic [OW-1:0] a, input logic [OW-1:0] e);
    n_checks++;
    if (a !== e) $display("FAIL %s: got %h expected %h", name, a, e);
    else n_pass++;
  endtask

  task automatic check_small(input string name, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) $display("FAIL %s: got %h expected %h", name, a, e);
    else n_pass++;
  endtask

  task automatic check_model(input string name);
    exp_q.push_back(model_out(m_instr, m_tag, bus.branch_ref));
    check(name, act, exp_q.pop_front());
  endtask

  // ---------------- driver tasks
  task automatic clk_step();
    @(posedge clk);
    if (rst) begin
      m_instr = NOP_W;
      m_tag   = 1'b0;
    end else if (!bus.sel_stall) begin
      m_instr = bus.instr_in;
      m_tag   = bus.branch_in;
    end
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic tag, input logic bref,
                       input logic stall);
    bus.instr_in   = ins;
    bus.branch_in  = tag;
    bus.branch_ref = bref;
    bus.sel_stall  = stall;
  endtask

  // ---------------- directed vector table
  typedef struct {
    logic [31:0] ins;
    logic        tag;
    logic        bref;
    logic [6:0]  exp_opc;
    logic        exp_en;
  } vec_t;
  vec_t vecs[15];

  initial begin
    vecs[0]  = '{32'h5155_5555, 1'b0, 1'b0, 7'b0111010, 1'b1};
    vecs[1]  = '{32'hE281_1004, 1'b0, 1'b0, 7'b0010100, 1'b0};
    vecs[2]  = '{32'hE791_2003, 1'b0, 1'b0, 7'b1010001, 1'b0};
    vecs[3]  = '{32'hAAAA_AAAA, 1'b1, 1'b1, 7'b1100000, 1'b0};
    vecs[4]  = '{32'hEB00_0010, 1'b0, 1'b0, 7'b1100001, 1'b0};
    vecs[5]  = '{32'hF281_1004, 1'b0, 1'b0, 7'b0100000, 1'b0};
    vecs[6]  = '{32'hE100_0000, 1'b0, 1'b0, 7'b0100000, 1'b0};
    vecs[7]  = '{32'hE091_2003, 1'b0, 1'b0, 7'b0000100, 1'b1};
    vecs[8]  = '{32'hE090_0090, 1'b0, 1'b0, 7'b0100000, 1'b0};
    vecs[9]  = '{32'hE591_2004, 1'b0, 1'b0, 7'b1000001, 1'b0};
    vecs[10] = '{32'hE791_2013, 1'b0, 1'b0, 7'b0100000, 1'b0};
    vecs[11] = '{32'hE320_0000, 1'b0, 1'b0, 7'b0100000, 1'b0};
    vecs[12] = '{32'hE310_0000, 1'b1, 1'b1, 7'b0011000, 1'b1};
    vecs[13] = '{32'h5155_5555, 1'b1, 1'b0, 7'b0100000, 1'b0};
    vecs[14] = '{32'hE800_0000, 1'b0, 1'b0, 7'b0100000, 1'b0};
  end

  // ---------------- test
  initial begin
    m_instr = NOP_W;
    m_tag   = 1'b0;
    rst = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    clk_step();
    clk_step();
    rst = 1'b0;
    #1;
    check_small("reset_opcode", {25'd0, bus.opcode}, 32'h20);
    check_small("reset_cond_rd", {24'd0, bus.cond, bus.rd}, 32'hEF);
    check_small("reset_en_p_w_bv", {28'd0, bus.en_status, bus.P, bus.W, bus.branch_value}, 32'h6);
    check_model("reset_all");

    foreach (vecs[i]) begin
      drive(vecs[i].ins, vecs[i].tag, vecs[i].bref, 1'b0);
      clk_step();
      check_small($sformatf("vec%0d_opc_en", i), {24'd0, bus.opcode, bus.en_status},
                  {24'd0, vecs[i].exp_opc, vecs[i].exp_en});
      check_model($sformatf("vec%0d_all", i));
    end

    // load, stall, release with mismatch, then redirect without a clock
    drive(32'h5155_5555, 1'b0, 1'b0, 1'b0);
    clk_step();
    check("load_5155", act, {4'h5, 7'b0111010, 1'b1, 4'h5, 4'h5, 4'h5, 4'h5, 2'b10, 5'b01010,
                             12'h555, 24'h555555, 1'b1, 1'b0, 1'b0, 1'b0});
    drive(32'hAEAA_AAAA, 1'b1, 1'b0, 1'b1);
    clk_step();
    check("stall_hold", act, {4'h5, 7'b0111010, 1'b1, 4'h5, 4'h5, 4'h5, 4'h5, 2'b10, 5'b01010,
                              12'h555, 24'h555555, 1'b1, 1'b0, 1'b0, 1'b0});
    bus.sel_stall = 1'b0;
    clk_step();
    check_small("mismatch_nop_opc", {25'd0, bus.opcode}, 32'h20);
    check_small("mismatch_nop_imm24", {8'd0, bus.imm24}, 32'h20F000);
    check_small("mismatch_bv", {31'd0, bus.branch_value}, 32'h1);
    check_model("mismatch_all");
    bus.branch_ref = 1'b1;
    #1;
    check_small("redirect_imm24", {8'd0, bus.imm24}, 32'hAAAAAA);
    check_small("redirect_cond", {28'd0, bus.cond}, 32'hA);
    check_model("redirect_all");

    // reset beats stall
    rst = 1'b1;
    bus.sel_stall = 1'b1;
    clk_step();
    rst = 1'b0;
    #1;
    check_small("rst_over_stall_opc_bv", {24'd0, bus.opcode, bus.branch_value}, {24'd0, 7'h20, 1'b0});
    check_model("rst_over_stall_all");

    // stalled mismatch keeps the instruction; it reappears when the epoch matches
    drive(32'hE281_1004, 1'b1, 1'b0, 1'b0);
    clk_step();
    bus.sel_stall = 1'b1;
    bus.instr_in  = 32'hE791_2003;
    clk_step();
    check_small("stall_mismatch_nop", {25'd0, bus.opcode}, 32'h20);
    bus.branch_ref = 1'b1;
    #1;
    check_small("stall_rematch_opc", {25'd0, bus.opcode}, 32'h14);
    check_model("stall_rematch_all");

    // random stimulus against the reference model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      drive($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) bus.instr_in[31:28] = 4'hE;
      clk_step();
      rst = 1'b0;
      #1;
      check_model($sformatf("rand%0d", i));
      bus.branch_ref = ~bus.branch_ref;
      #1;
      check_model($sformatf("rand%0d_flip", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
